alu_share_arbiter: RTL and testbench

//  Shares the single 32-bit ALU between two requesters: r0, the EX-stage issue,
//  and r1, the auxiliary/address-gen path. Each requester uses a valid/ready

---
 rtl/alu_share_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Shares one 32-bit ALU between r0 (EX issue) and r1 (aux/address-gen), with a one-entry response slot per requester.
// Optional build macro ALU_ARB_FIXED_PRIO_EN: r0 wins ties, and r1 is forced after STARVE_LIMIT consecutive losses.
//
//  state        | meaning
//  rr_ptr = 0   | r0 was granted last; r1 wins the next tie (round-robin build)
//  rr_ptr = 1   | r1 was granted last, or just out of reset; r0 wins the next tie
//  starve_cnt   | consecutive cycles r1 was eligible but not granted (fixed-priority build)
module alu_share_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int STARVE_W     = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        r0_valid,
   output logic        r0_ready,
   input  logic [3:0]  r0_opcode,
   input  logic [31:0] r0_x,
   input  logic [31:0] r0_y,
   output logic        r0_rsp_valid,
   input  logic        r0_rsp_ready,
   output logic [31:0] r0_result,
   output logic        r0_overflow,
   output logic        r0_y_zero,
   input  logic        r1_valid,
   output logic        r1_ready,
   input  logic [3:0]  r1_opcode,
   input  logic [31:0] r1_x,
   input  logic [31:0] r1_y,
   output logic        r1_rsp_valid,
   input  logic        r1_rsp_ready,
   output logic [31:0] r1_result,
   output logic        r1_overflow,
   output logic        r1_y_zero,
   output logic [3:0]  alu_opcode,
   output logic [31:0] alu_op_x,
   output logic [31:0] alu_op_y,
   input  logic [31:0] alu_result,
   input  logic        alu_overflow,
   input  logic        alu_op_y_zero,
   output logic [1:0]  grant_id
);

   logic elig0, elig1;
   logic gnt0, gnt1;

   // A full slot can still accept if it is being drained in the same cycle.
   assign elig0 = ~rst & r0_valid & (~r0_rsp_valid | r0_rsp_ready);
   assign elig1 = ~rst & r1_valid & (~r1_rsp_valid | r1_rsp_ready);

`ifdef ALU_ARB_FIXED_PRIO_EN
   logic [STARVE_W-1:0] starve_cnt;
   logic                starved;

   assign starved = (starve_cnt == STARVE_W'(STARVE_LIMIT));

   always_comb begin
      gnt1 = elig1 & (~elig0 | starved);
      gnt0 = elig0 & ~gnt1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (elig1 & ~gnt1) begin
         if (!starved) starve_cnt <= starve_cnt + 1'b1;
      end else begin
         starve_cnt <= '0;
      end
   end
`else
   logic rr_ptr;

   always_comb begin
      gnt0 = elig0 & (~elig1 | rr_ptr);
      gnt1 = elig1 & ~gnt0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= 1'b1;
      end else if (gnt0) begin
         rr_ptr <= 1'b0;
      end else if (gnt1) begin
         rr_ptr <= 1'b1;
      end
   end
`endif

   assign r0_ready = gnt0;
   assign r1_ready = gnt1;
   assign grant_id = {gnt1, gnt0};

   always_comb begin
      alu_opcode = 4'h0;
      alu_op_x   = '0;
      alu_op_y   = '0;
      if (gnt0) begin
         alu_opcode = r0_opcode;
         alu_op_x   = r0_x;
         alu_op_y   = r0_y;
      end else if (gnt1) begin
         alu_opcode = r1_opcode;
         alu_op_x   = r1_x;
         alu_op_y   = r1_y;
      end
   end

   // Response slots: data is held after a drain, only the valid flag drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         r0_rsp_valid <= 1'b0;
         r0_result    <= '0;
         r0_overflow  <= 1'b0;
         r0_y_zero    <= 1'b0;
      end else if (gnt0) begin
         r0_rsp_valid <= 1'b1;
         r0_result    <= alu_result;
         r0_overflow  <= alu_overflow;
         r0_y_zero    <= alu_op_y_zero;
      end else if (r0_rsp_ready) begin
         r0_rsp_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r1_rsp_valid <= 1'b0;
         r1_result    <= '0;
         r1_overflow  <= 1'b0;
         r1_y_zero    <= 1'b0;
      end else if (gnt1) begin
         r1_rsp_valid <= 1'b1;
         r1_result    <= alu_result;
         r1_overflow  <= alu_overflow;
         r1_y_zero    <= alu_op_y_zero;
      end else if (r1_rsp_ready) begin
         r1_rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized scoreboard bench for alu_share_arbiter; a behavioural ALU stands in for the shared unit.
// Honours ALU_ARB_FIXED_PRIO_EN in its arbitration model when the design is built with it.
module tb_alu_share_arbiter;

   localparam int STARVE_LIMIT = 4;
   localparam int N_CYCLES     = 3000;

   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                          OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7;

   logic        clk = 1'b0;
   logic        rst;
   logic        rv  [2];
   logic [3:0]  rop [2];
   logic [31:0] rx  [2];
   logic [31:0] ry  [2];
   logic        rrr [2];

   logic        r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid;
   logic [31:0] r0_result, r1_result;
   logic        r0_overflow, r1_overflow, r0_y_zero, r1_y_zero;
   logic [3:0]  alu_opcode;
   logic [31:0] alu_op_x, alu_op_y, alu_result;
   logic        alu_overflow, alu_op_y_zero;
   logic [1:0]  grant_id;

   alu_share_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .STARVE_W(3)) dut (
      .clk(clk), .rst(rst),
      .r0_valid(rv[0]), .r0_ready(r0_ready), .r0_opcode(rop[0]), .r0_x(rx[0]), .r0_y(ry[0]),
      .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(rrr[0]), .r0_result(r0_result),
      .r0_overflow(r0_overflow), .r0_y_zero(r0_y_zero),
      .r1_valid(rv[1]), .r1_ready(r1_ready), .r1_opcode(rop[1]), .r1_x(rx[1]), .r1_y(ry[1]),
      .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(rrr[1]), .r1_result(r1_result),
      .r1_overflow(r1_overflow), .r1_y_zero(r1_y_zero),
      .alu_opcode(alu_opcode), .alu_op_x(alu_op_x), .alu_op_y(alu_op_y),
      .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_op_y_zero(alu_op_y_zero),
      .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   // Returns {overflow, y_zero, result}.
   function automatic logic [33:0] alu_ref(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      logic [31:0] r;
      logic        v;
      v = 1'b0;
      case (op)
         OP_ADD: begin r = x + y; v = (x[31] == y[31]) && (r[31] != x[31]); end
         OP_SUB: begin r = x - y; v = (x[31] != y[31]) && (r[31] != x[31]); end
         OP_AND: r = x & y;
         OP_OR:  r = x | y;
         OP_XOR: r = x ^ y;
         OP_SLL: r = y << x[4:0];
         OP_SRL: r = y >> x[4:0];
         OP_SRA: r = $unsigned($signed(y) >>> x[4:0]);
         default: r = '0;
      endcase
      return {v, (y == 32'd0), r};
   endfunction

   always_comb {alu_overflow, alu_op_y_zero, alu_result} = alu_ref(alu_opcode, alu_op_x, alu_op_y);

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
   endtask

   logic [33:0] q [2][$];
   int          last_winner = 1;
   int          starve = 0;
   bit          post_rst = 1'b0;
   logic        acc [2];

   initial begin
      acc[0] = 1'b0;
      acc[1] = 1'b0;
   end

   always @(negedge clk) begin
      logic        e0, e1;
      int          g;
      logic [31:0] rsl [2];
      logic        ovf [2], yz [2], rspv [2];
      rsl[0] = r0_result;   rsl[1] = r1_result;
      ovf[0] = r0_overflow; ovf[1] = r1_overflow;
      yz[0]  = r0_y_zero;   yz[1]  = r1_y_zero;
      rspv[0] = r0_rsp_valid; rspv[1] = r1_rsp_valid;
      if (rst) begin
         chk("ready_in_reset", {62'd0, r1_ready, r0_ready}, 64'd0);
         q[0].delete();
         q[1].delete();
         last_winner = 1;
         starve = 0;
         post_rst = 1'b1;
         acc[0] = 1'b0;
         acc[1] = 1'b0;
      end else begin
         if (post_rst) begin
            chk("post_reset_r0_data", {30'd0, r0_overflow, r0_y_zero, r0_result}, 64'd0);
            chk("post_reset_r1_data", {30'd0, r1_overflow, r1_y_zero, r1_result}, 64'd0);
            post_rst = 1'b0;
         end
         e0 = rv[0] && (q[0].size() == 0 || rrr[0]);
         e1 = rv[1] && (q[1].size() == 0 || rrr[1]);
         if (e0 && e1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            g = (starve >= STARVE_LIMIT) ? 1 : 0;
`else
            g = 1 - last_winner;
`endif
         end else if (e0) g = 0;
         else if (e1) g = 1;
         else g = -1;

         chk("grant_id", {62'd0, grant_id}, (g == 0) ? 64'd1 : (g == 1) ? 64'd2 : 64'd0);
         chk("ready", {62'd0, r1_ready, r0_ready}, (g == 0) ? 64'd1 : (g == 1) ? 64'd2 : 64'd0);
         if (g >= 0)
            chk("alu_drive", {alu_opcode, alu_op_x, alu_op_y}, {rop[g], rx[g], ry[g]});
         else
            chk("alu_idle", {alu_opcode, alu_op_x, alu_op_y}, 68'd0);

         for (int n = 0; n < 2; n++) begin
            chk($sformatf("r%0d_rsp_valid", n), {63'd0, rspv[n]}, {63'd0, q[n].size() != 0});
            if (q[n].size() != 0) begin
               chk($sformatf("r%0d_rsp_data", n), {30'd0, ovf[n], yz[n], rsl[n]}, {30'd0, q[n][0]});
               if (rrr[n]) void'(q[n].pop_front());
            end
            acc[n] = (g == n);
         end

         if (g >= 0) begin
            q[g].push_back(alu_ref(rop[g], rx[g], ry[g]));
            last_winner = g;
         end
         if (e1 && g != 1) starve++;
         else starve = 0;
      end
   end

   int n_dir [2];

   function automatic logic [31:0] rand_opnd();
      logic [31:0] sp [6];
      sp[0] = 32'd0; sp[1] = 32'd1; sp[2] = 32'h7FFF_FFFF;
      sp[3] = 32'h8000_0000; sp[4] = 32'hFFFF_FFFF; sp[5] = 32'd4;
      if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 5)];
      return $urandom();
   endfunction

   task automatic new_req(input int n, input bit force_valid);
      rv[n] = 1'b1;
      if (n == 0 && n_dir[0] < 6) begin
         if (n_dir[0] < 5) begin rop[0] = OP_ADD; rx[0] = 32'd5; ry[0] = 32'd7; end
         else begin rop[0] = OP_ADD; rx[0] = 32'd1; ry[0] = 32'd3; end
         n_dir[0]++;
      end else if (n == 1 && n_dir[1] < 3) begin
         case (n_dir[1])
            0: begin rop[1] = OP_SUB; rx[1] = 32'h8000_0000; ry[1] = 32'd1; end
            1: begin rop[1] = OP_OR;  rx[1] = 32'h0000_0005; ry[1] = 32'd0; end
            default: begin rop[1] = OP_SRA; rx[1] = 32'd4; ry[1] = 32'hF000_0000; end
         endcase
         n_dir[1]++;
      end else begin
         rv[n]  = force_valid || ($urandom_range(0, 9) < 8);
         rop[n] = 4'($urandom_range(0, 7));
         rx[n]  = rand_opnd();
         ry[n]  = rand_opnd();
      end
   endtask

   initial begin
      #(10 * 100000);
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      int phase;
      rst = 1'b1;
      n_dir[0] = 0;
      n_dir[1] = 0;
      for (int n = 0; n < 2; n++) begin
         rv[n] = 1'b0; rop[n] = 4'd0; rx[n] = '0; ry[n] = '0; rrr[n] = 1'b1;
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < N_CYCLES; i++) begin
         @(posedge clk);
         #1;
         phase = i % 400;
         rst = (phase == 393);
         for (int n = 0; n < 2; n++) begin
            if (!rv[n] || acc[n]) new_req(n, phase >= 386 && phase <= 393);
            if (i < 12) rrr[n] = 1'b1;
            else if (phase >= 386 && phase <= 393) rrr[n] = 1'b0;
            else rrr[n] = ($urandom_range(0, 9) < 7);
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int n = 0; n < 2; n++) begin
         rv[n] = 1'b0;
         rrr[n] = 1'b1;
      end
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("drained_rsp_valid", {62'd0, r1_rsp_valid, r0_rsp_valid}, 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
